// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter for the register-file write port: fixed priority to
// the main pipeline (A), with a starvation counter that forces a grant to source B.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [ADDR_W-1:0] a_rd_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic [ADDR_W-1:0] b_rd_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_rd_o,
  output logic [DATA_W-1:0] rf_wdata_o,
  output logic              b_forced_o
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  // state | meaning
  // A_PRI   | normal operation, A wins whenever it is valid
  // B_FORCE | B starved STARVE_LIMIT cycles; only B may transfer
  localparam logic [0:0] A_PRI   = 1'b0;
  localparam logic [0:0] B_FORCE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              a_xfer, b_xfer;
  logic [CNT_W-1:0]  cnt_inc;

  assign cnt_inc = starve_cnt_q + CNT_W'(1);

  always_comb begin
    a_ready_o    = 1'b0;
    b_ready_o    = 1'b0;
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    if (state_q == A_PRI) begin
      a_ready_o = a_valid_i;
      b_ready_o = b_valid_i && !a_valid_i;
    end else begin
      b_ready_o = b_valid_i;
    end

    a_xfer = a_valid_i && a_ready_o;
    b_xfer = b_valid_i && b_ready_o;

    if (state_q == A_PRI) begin
      if (b_xfer) begin
        starve_cnt_d = '0;
      end else if (b_valid_i) begin
        starve_cnt_d = cnt_inc;
        if (cnt_inc == CNT_W'(STARVE_LIMIT)) state_d = B_FORCE;
      end
    end else begin
      // A forced grant that B no longer wants is abandoned without a write.
      if (b_xfer || !b_valid_i) begin
        state_d      = A_PRI;
        starve_cnt_d = '0;
      end
    end
  end

  // x0 transfers are acknowledged but never reach the register file.
  always_comb begin
    rf_we_d    = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (a_xfer && (a_rd_i != '0)) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = a_rd_i;
      rf_wdata_d = a_data_i;
    end else if (b_xfer && (b_rd_i != '0)) begin
      rf_we_d    = 1'b1;
      rf_rd_d    = b_rd_i;
      rf_wdata_d = b_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= A_PRI;
      starve_cnt_q <= '0;
      rf_we_q      <= 1'b0;
      rf_rd_q      <= '0;
      rf_wdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      rf_we_q      <= rf_we_d;
      rf_rd_q      <= rf_rd_d;
      rf_wdata_q   <= rf_wdata_d;
    end
  end

  assign rf_we_o    = rf_we_q;
  assign rf_rd_o    = rf_rd_q;
  assign rf_wdata_o = rf_wdata_q;
  assign b_forced_o = (state_q == B_FORCE);

endmodule
